// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pipe_ctrl_pkg / pipe_ctrl_if                                 |
// | Description : Shared types and the request/response bundle between the    |
// |               pipeline stages and the stall/flush scheduler.              |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------

package pipe_ctrl_pkg;
   typedef logic reset_status_t;
   localparam reset_status_t RST_ENABLE = 1'b0;
   localparam logic [31:0]   ERET_CODE  = 32'h0000_000E;
endpackage

interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        excp_valid;
   logic [31:0] excp_type;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        wdog_timeout;
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;

   // Pipeline side: raises requests, consumes stall/flush controls
   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output excp_valid, excp_type, cp0_epc,
      input  stall, flush, new_pc, wdog_timeout,
      input  perf_stall_cycles, perf_flush_count
   );

   // Scheduler side
   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  excp_valid, excp_type, cp0_epc,
      output stall, flush, new_pc, wdog_timeout,
      output perf_stall_cycles, perf_flush_count
   );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : pipe_ctrl                                                   |
// | Description : Pipeline stall/flush scheduler with deferred exception      |
// |               handling and a stuck-pipeline watchdog.                     |
// |               Optional perf counters enabled by PIPE_CTRL_PERF_EN.        |
// | Revision    : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXCP_ENTRY = 32'h0000_0020,
   parameter int          WDOG_LIMIT = 1024
) (
   input  logic          clk,
   input  reset_status_t rst,
   pipe_ctrl_if.slave    bus
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [15:0] c_WDOG_LIMIT = 16'(WDOG_LIMIT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_excp_type;
   logic [31:0] r_excp_epc;
   logic        w_latch;
   logic        w_rst_act;
   logic [5:0]  w_prio_stall;
   logic [5:0]  w_stall;
   logic        w_flush;
   logic [31:0] w_new_pc;
   logic [15:0] r_wdog_cnt;
   logic [15:0] w_wdog_nxt;
   logic        r_wdog_to;

   assign w_rst_act = (rst == RST_ENABLE);

   // Priority encode stage requests: the oldest stalled stage freezes all younger ones
   always_comb begin
      w_prio_stall = 6'b000000;
      if (bus.stallreq_mem)
         w_prio_stall = 6'b011111;
      else if (bus.stallreq_ex)
         w_prio_stall = 6'b001111;
      else if (bus.stallreq_id)
         w_prio_stall = 6'b000111;
      else if (bus.stallreq_if)
         w_prio_stall = 6'b000011;
   end

   // Exception sequencing: flush immediately, or defer until MEM is ready
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = w_prio_stall;
      w_flush     = 1'b0;
      w_new_pc    = 32'h0;
      w_latch     = 1'b0;
      if (w_rst_act) begin
         w_state_nxt = RUN;
         w_stall     = 6'b000000;
      end else begin
         case (r_state)
            RUN: begin
               if (bus.excp_valid) begin
                  if (bus.stallreq_mem) begin
                     w_latch     = 1'b1;
                     w_state_nxt = PEND;
                  end else begin
                     w_flush  = 1'b1;
                     w_stall  = 6'b000000;
                     w_new_pc = (bus.excp_type == ERET_CODE) ? bus.cp0_epc : EXCP_ENTRY;
                  end
               end
            end
            PEND: begin
               // New exceptions are ignored here; the latched one owns the redirect
               if (!bus.stallreq_mem) begin
                  w_flush     = 1'b1;
                  w_stall     = 6'b000000;
                  w_new_pc    = (r_excp_type == ERET_CODE) ? r_excp_epc : EXCP_ENTRY;
                  w_state_nxt = RUN;
               end
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   // State register and capture of the deferred exception
   always_ff @(posedge clk) begin
      if (w_rst_act) begin
         r_state     <= RUN;
         r_excp_type <= 32'h0;
         r_excp_epc  <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_excp_type <= bus.excp_type;
            r_excp_epc  <= bus.cp0_epc;
         end
      end
   end

   // Watchdog next count: saturating run length of PC stalls, cleared by a flush
   always_comb begin
      w_wdog_nxt = 16'h0;
      if (w_stall[0] && !w_flush)
         w_wdog_nxt = (r_wdog_cnt == c_WDOG_LIMIT) ? r_wdog_cnt : r_wdog_cnt + 16'd1;
   end

   // Timeout flag follows the count that is being stored this edge
   always_ff @(posedge clk) begin
      if (w_rst_act) begin
         r_wdog_cnt <= 16'h0;
         r_wdog_to  <= 1'b0;
      end else begin
         r_wdog_cnt <= w_wdog_nxt;
         r_wdog_to  <= (w_wdog_nxt == c_WDOG_LIMIT);
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   // Free-running event counters; natural wrap at 32 bits
   always_ff @(posedge clk) begin
      if (w_rst_act) begin
         r_perf_stall <= 32'h0;
         r_perf_flush <= 32'h0;
      end else begin
         if (w_stall[0])
            r_perf_stall <= r_perf_stall + 32'd1;
         if (w_flush)
            r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign bus.perf_stall_cycles = r_perf_stall;
   assign bus.perf_flush_count  = r_perf_flush;
`else
   assign bus.perf_stall_cycles = 32'h0;
   assign bus.perf_flush_count  = 32'h0;
`endif

   assign bus.stall        = w_stall;
   assign bus.flush        = w_flush;
   assign bus.new_pc       = w_new_pc;
   assign bus.wdog_timeout = r_wdog_to;

endmodule

`default_nettype wire
